// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder standing in for the PmodJSTK: serves X/Y/buttons, decodes the LED command byte.
// Latency: SYNC_STAGES+1 clk cycles from any SPI pin edge to its effect on miso or the frame pulses.
// Backpressure: none; the master paces the link and SCLK phases must each last >= 4 clk cycles.
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led_cmd,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int         FRAME_BITS = 8 * FRAME_BYTES;
    localparam logic [5:0] CNT_FULL   = 6'(FRAME_BITS);
    localparam logic [5:0] CNT_SAT    = 6'(FRAME_BITS + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                   state, state_nxt;
    logic [SYNC_STAGES-1:0]   sclk_sync, ss_sync, mosi_sync, fill_sr;
    logic                     sclk_d, ss_d, armed;
    logic                     sclk_q, ss_q, mosi_q;
    logic                     sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic                     load, end_frame, shift_rx, shift_tx;
    logic [FRAME_BITS-1:0]    tx_sr, rx_sr, tx_load;
    logic [5:0]               bit_cnt;
    logic                     cmd_ok;

    assign sclk_q = sclk_sync[SYNC_STAGES-1];
    assign ss_q   = ss_sync[SYNC_STAGES-1];
    assign mosi_q = mosi_sync[SYNC_STAGES-1];

    // fill_sr marks when the ss chain holds a real sample, so an ss already low
    // at reset release is never mistaken for a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            fill_sr   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            fill_sr   <= {fill_sr[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_q;
            ss_d      <= ss_q;
            armed     <= armed | (fill_sr[SYNC_STAGES-1] & ss_q);
        end
    end

    assign sclk_rise = sclk_q & ~sclk_d;
    assign sclk_fall = ~sclk_q & sclk_d;
    assign ss_rise   = ss_q & ~ss_d;
    assign ss_fall   = ~ss_q & ss_d & armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ss rise takes priority over a coincident sclk edge
    always_comb begin
        load      = 1'b0;
        end_frame = 1'b0;
        shift_rx  = 1'b0;
        shift_tx  = 1'b0;
        miso      = 1'b0;
        case (state)
            IDLE:   load = ss_fall;
            ACTIVE: begin
                end_frame = ss_rise;
                shift_rx  = sclk_rise & ~ss_rise;
                shift_tx  = sclk_fall & ~ss_rise;
                miso      = tx_sr[FRAME_BITS-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_load = '0;
        tx_load[FRAME_BITS-1 -: 40] = {y_pos[7:0], 6'b0, y_pos[9:8],
                                       x_pos[7:0], 6'b0, x_pos[9:8], 5'b0, btn};
    end

    assign cmd_ok = (rx_sr[FRAME_BITS-1 -: 6] == 6'b100000) && (bit_cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            led_cmd    <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= end_frame & cmd_ok;
            frame_err  <= end_frame & ~cmd_ok;
            if (end_frame && cmd_ok)
                led_cmd <= rx_sr[FRAME_BITS-7 -: 2];
            if (load) begin
                tx_sr   <= tx_load;
                rx_sr   <= '0;
                bit_cnt <= '0;
            end
            if (shift_rx) begin
                rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_q};
                if (bit_cnt != CNT_SAT)
                    bit_cnt <= bit_cnt + 6'd1;
            end
            if (shift_tx)
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
    end

endmodule
